commit_trace_queue: RTL and testbench
=====================================

// Module: commit_trace_queue
// PURPOSE
//  Producer end of the instruction-trace interface: takes retire events from the WB
//  stage, buffers them, and drives {inst, dnpc, valid} to the DPI trace sink.
//  The DPI sink consumes one record per out_valid&&out_ready.
//  Detects EBREAK, drains all pending records, then raises a sticky halt for the
//  simulation harness.
// PARAMETERS
//  DEPTH   4             FIFO entries (power of 2, >=2); output register adds 1 slot
//  XLEN    64            width of dnpc and commit counter
//  ILEN    32            instruction width
//  EBREAK  32'h00100073  encoding that triggers drain/halt
// PORTS
//  clock       in   1     system clock, all state on rising edge
//  reset_n     in   1     asynchronous, active-low reset
//  in_valid    in   1     WB retire event valid
//  in_ready    out  1     queue accepts event (registered, no comb path from in_valid)
//  in_inst     in   ILEN  retired instruction
//  in_dnpc     in   XLEN  next pc after retirement
//  out_valid   out  1     trace record valid toward DPI sink
//  out_ready   in   1     sink accepts record this cycle
//  out_inst    out  ILEN  trace instruction
//  out_dnpc    out  XLEN  trace next pc
//  halt        out  1     sticky: EBREAK traced and queue fully drained
//  commit_cnt  out  XLEN  number of records delivered to sink
// BEHAVIOUR
//  - Reset (async assert, sync deassert in harness): FIFO empty, ptrs 0, state RUN,
//    out_valid=0, out_inst=0, out_dnpc=0, halt=0, commit_cnt=0, in_ready=1.
//    Reset mid-operation discards every queued record; no record is emitted for it.
//  - push = in_valid && in_ready; pop (sink) = out_valid && out_ready.
//  - Storage: DEPTH-entry FIFO (wr/rd ptrs with extra wrap bit) + output register.
//  - Output register loads when (!out_valid || out_ready):
//      FIFO non-empty -> head entry (FIFO pop); else if push -> bypass input directly;
//      else out_valid<=0. Min latency push->out_valid = 1 cycle.
//  - Ordering strictly FIFO; bypass only when FIFO empty (never overtakes).
//  - out_valid/out_inst/out_dnpc held stable while out_valid && !out_ready.
//  - in_ready = (state==RUN) && !full_next, computed as register; when full, a
//    same-cycle pop does NOT allow a same-cycle push (in_ready already 0).
//  - Pointer wrap: index = ptr[log2(DEPTH)-1:0]; full = MSBs differ, idx equal.
//  - Simultaneous FIFO push & pop when non-empty: count unchanged, both ptrs advance.
//  - FSM: RUN -> DRAIN on push with in_inst==EBREAK (EBREAK record itself is queued
//    and traced); DRAIN: in_ready=0, keep delivering;
//    DRAIN -> HALTED when FIFO empty && pop of final record (or out_valid==0).
//    HALTED: in_ready=0, halt=1, out_valid=0; left only by reset.
//  - in_valid while in_ready=0: ignored, no state change (WB must hold).
//  - commit_cnt += 1 on every pop, modulo 2^XLEN (wraps to 0).
// STRUCTURE
//  - Package trace_pkg: typedef struct packed {logic [ILEN-1:0] inst;
//    logic [XLEN-1:0] dnpc;} trace_rec_t; localparam EBREAK_INST; typedef enum
//    logic [1:0] {TQ_RUN, TQ_DRAIN, TQ_HALTED} tq_state_t.
//  - Sub-module trace_fifo (DEPTH x trace_rec_t, push/pop/full/empty/head) instantiated
//    once; FSM, bypass/output register and counter live in the top.
// TESTING
//  1 Single push inst=0x00000013 dnpc=0x80000004, out_ready=1 -> out_valid next cycle
//    with same values, commit_cnt=1, halt=0.
//  2 out_ready=0, push 5 records (DEPTH=4) -> in_ready falls after 5th accepted
//    (4 FIFO+1 out reg); release out_ready -> records emerge in order, 1/cycle.
//  3 Full queue, in_valid=1 and out_ready=1 same cycle -> pop occurs, push refused,
//    in_ready=1 next cycle; no record lost or duplicated.
//  4 Push 0x00000013, 0x00100073, then in_valid held -> EBREAK traced last,
//    in_ready=0 after EBREAK, halt=1 one cycle after final pop, commit_cnt=2.
//  5 Assert reset_n=0 with 3 queued records -> all outputs 0 immediately, no further
//    out_valid after release until new push.
//  6 Preload commit_cnt path to 2^64-1 (force) then one pop -> commit_cnt=0.

Source files
------------

// File: rtl/commit_trace_queue_pkg.sv
// Shared types for the instruction-trace producer: the trace record layout,
// the EBREAK encoding and the drain/halt state encoding.
package trace_pkg;

    localparam int unsigned TQ_ILEN = 32;
    localparam int unsigned TQ_XLEN = 64;

    localparam logic [TQ_ILEN-1:0] EBREAK_INST = 32'h0010_0073;

    typedef struct packed {
        logic [TQ_ILEN-1:0] inst;
        logic [TQ_XLEN-1:0] dnpc;
    } trace_rec_t;

    typedef enum logic [1:0] {
        TQ_RUN    = 2'd0,
        TQ_DRAIN  = 2'd1,
        TQ_HALTED = 2'd2
    } tq_state_t;

endpackage

// File: rtl/commit_trace_queue_fifo.sv
// DEPTH-entry FIFO of trace records, wrap-bit pointers, with a look-ahead
// full flag so the owner can register its ready output.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       push,
    input  logic       pop,
    input  trace_rec_t wr_data,
    output trace_rec_t head,
    output logic       full,
    output logic       empty,
    output logic       full_next
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    trace_rec_t  mem_q [DEPTH];

    // Pointer advance and occupancy flags.
    always_comb begin
        wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty     = (wr_ptr_q == rd_ptr_q);
        full_next = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        head      = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Pointer registers; reset empties the queue.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Record storage; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/commit_trace_queue.sv
// Trace producer: buffers WB retire events and drives them to the DPI sink,
// draining and halting after an EBREAK has been traced.
module commit_trace_queue
    import trace_pkg::*;
#(
    parameter int unsigned     DEPTH  = 4,
    parameter int unsigned     XLEN   = TQ_XLEN,
    parameter int unsigned     ILEN   = TQ_ILEN,
    parameter logic [ILEN-1:0] EBREAK = EBREAK_INST
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_dnpc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_inst,
    output logic [XLEN-1:0] out_dnpc,
    output logic            halt,
    output logic [XLEN-1:0] commit_cnt
);

    tq_state_t       state_q, state_d;
    logic            out_valid_q, out_valid_d;
    trace_rec_t      out_rec_q, out_rec_d;
    logic            in_ready_q, in_ready_d;
    logic            halt_q, halt_d;
    logic [XLEN-1:0] commit_cnt_q, commit_cnt_d;

    logic       push_s, pop_s, load_s, bypass_s;
    logic       fifo_push_s, fifo_pop_s;
    logic       fifo_full_s, fifo_empty_s, fifo_full_next_s;
    trace_rec_t in_rec_s, fifo_head_s;

    // Handshakes; bypass only when nothing older is waiting in the FIFO.
    always_comb begin
        in_rec_s.inst = in_inst;
        in_rec_s.dnpc = in_dnpc;
        push_s        = in_valid && in_ready_q;
        pop_s         = out_valid_q && out_ready;
        load_s        = !out_valid_q || out_ready;
        fifo_pop_s    = load_s && !fifo_empty_s;
        bypass_s      = load_s && fifo_empty_s && push_s;
        fifo_push_s   = push_s && !bypass_s && !fifo_full_s;
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push_s),
        .pop       (fifo_pop_s),
        .wr_data   (in_rec_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .full_next (fifo_full_next_s)
    );

    // Drain/halt state machine.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TQ_RUN: begin
                if (push_s && (in_inst == EBREAK)) begin
                    state_d = TQ_DRAIN;
                end else begin
                    state_d = TQ_RUN;
                end
            end
            TQ_DRAIN: begin
                if (fifo_empty_s && (pop_s || !out_valid_q)) begin
                    state_d = TQ_HALTED;
                end else begin
                    state_d = TQ_DRAIN;
                end
            end
            TQ_HALTED: state_d = TQ_HALTED;
            default:   state_d = TQ_HALTED;
        endcase
    end

    // Output register, registered ready/halt and the delivery counter.
    always_comb begin
        out_valid_d = out_valid_q;
        out_rec_d   = out_rec_q;
        if (state_q == TQ_HALTED) begin
            out_valid_d = 1'b0;
        end else if (load_s) begin
            if (!fifo_empty_s) begin
                out_valid_d = 1'b1;
                out_rec_d   = fifo_head_s;
            end else if (push_s) begin
                out_valid_d = 1'b1;
                out_rec_d   = in_rec_s;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
        in_ready_d   = (state_d == TQ_RUN) && !fifo_full_next_s;
        halt_d       = (state_d == TQ_HALTED);
        commit_cnt_d = commit_cnt_q + {{(XLEN-1){1'b0}}, pop_s};
    end

    // State registers; reset discards anything in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= TQ_RUN;
            out_valid_q  <= 1'b0;
            out_rec_q    <= '0;
            in_ready_q   <= 1'b1;
            halt_q       <= 1'b0;
            commit_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_rec_q    <= out_rec_d;
            in_ready_q   <= in_ready_d;
            halt_q       <= halt_d;
            commit_cnt_q <= commit_cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_inst   = out_rec_q.inst;
    assign out_dnpc   = out_rec_q.dnpc;
    assign halt       = halt_q;
    assign commit_cnt = commit_cnt_q;

endmodule

// File: tb/tb_commit_trace_queue.sv
// Randomized bench for commit_trace_queue against a queue-based model of the
// trace stream (capacity DEPTH+1, in-order delivery, drain/halt after EBREAK).
module tb_commit_trace_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] EBRK  = 32'h0010_0073;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_dnpc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_dnpc;
    logic        halt;
    logic [63:0] commit_cnt;

    commit_trace_queue #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_dnpc    (in_dnpc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_dnpc   (out_dnpc),
        .halt       (halt),
        .commit_cnt (commit_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [95:0] mq[$];
    bit          m_drain;
    bit          m_halt;
    logic [63:0] m_cnt;
    bit          force_cnt;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit exp_ready();
        return !m_drain && !m_halt && (mq.size() < DEPTH + 1);
    endfunction

    task automatic check_outputs();
        chk_val("out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
        if (mq.size() > 0) begin
            chk_val("out_inst", {32'd0, out_inst}, {32'd0, mq[0][95:64]});
            chk_val("out_dnpc", out_dnpc, mq[0][63:0]);
        end
        chk_val("in_ready", {63'd0, in_ready}, {63'd0, exp_ready()});
        chk_val("halt", {63'd0, halt}, {63'd0, m_halt});
        chk_val("commit_cnt", commit_cnt, m_cnt);
    endtask

    // One clock: drive at negedge, advance the model, check at next negedge.
    task automatic step(input bit iv, input logic [31:0] inst, input logic [63:0] dnpc, input bit ordy);
        bit push;
        bit pop;
        in_valid  = iv;
        in_inst   = inst;
        in_dnpc   = dnpc;
        out_ready = ordy;
        push = iv && exp_ready();
        pop  = (mq.size() > 0) && ordy;
        if (force_cnt) m_cnt = {64{1'b1}};
        if (pop) begin
            void'(mq.pop_front());
            m_cnt = m_cnt + 64'd1;
        end
        if (push) begin
            mq.push_back({inst, dnpc});
            if (inst == EBRK) m_drain = 1'b1;
        end
        if (m_drain && mq.size() == 0) m_halt = 1'b1;
        if (force_cnt) begin
            force dut.commit_cnt_q = {64{1'b1}};
            #2;
            release dut.commit_cnt_q;
        end
        @(posedge clock);
        @(negedge clock);
        check_outputs();
    endtask

    // Asynchronous reset mid-cycle, checked while asserted.
    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk_val("rst_out_inst", {32'd0, out_inst}, 64'd0);
        chk_val("rst_out_dnpc", out_dnpc, 64'd0);
        chk_val("rst_halt", {63'd0, halt}, 64'd0);
        chk_val("rst_cnt", commit_cnt, 64'd0);
        chk_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clock);
        reset_n = 1'b1;
        mq.delete();
        m_drain = 1'b0;
        m_halt  = 1'b0;
        m_cnt   = 64'd0;
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [31:0] v;
        v = $urandom;
        if (v == EBRK) v = v ^ 32'h1;
        return v;
    endfunction

    initial begin
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_inst   = 32'd0;
        in_dnpc   = 64'd0;
        out_ready = 1'b0;
        force_cnt = 1'b0;
        m_drain   = 1'b0;
        m_halt    = 1'b0;
        m_cnt     = 64'd0;
        @(negedge clock);
        do_reset();
        @(negedge clock);
        check_outputs();

        // Single record, 1-cycle latency.
        step(1'b1, 32'h0000_0013, 64'h8000_0004, 1'b1);
        chk_val("t1_valid", {63'd0, out_valid}, 64'd1);
        chk_val("t1_inst", {32'd0, out_inst}, 64'h13);
        step(1'b0, 32'd0, 64'd0, 1'b1);
        chk_val("t1_cnt", commit_cnt, 64'd1);

        // Fill with sink stalled, then drain in order.
        for (int i = 0; i < 7; i++) step(1'b1, 32'h100 + i, 64'h1000 + i, 1'b0);
        chk_val("t2_in_ready", {63'd0, in_ready}, 64'd0);
        // Full: pop and push in the same cycle; the push is refused.
        step(1'b1, 32'h200, 64'h2000, 1'b1);
        chk_val("t3_in_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 7; i++) step(1'b0, 32'd0, 64'd0, 1'b1);

        // EBREAK: traced last, then halt.
        do_reset();
        step(1'b1, 32'h0000_0013, 64'h8000_0004, 1'b1);
        step(1'b1, EBRK, 64'h8000_0008, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 32'h33, 64'h8000_000c, 1'b1);
        chk_val("t4_halt", {63'd0, halt}, 64'd1);
        chk_val("t4_cnt", commit_cnt, 64'd2);

        // Reset with queued records, then nothing emerges.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, rnd_inst(), {$urandom, $urandom}, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 64'd0, 1'b1);

        // Counter wrap.
        step(1'b1, rnd_inst(), {$urandom, $urandom}, 1'b0);
        force_cnt = 1'b1;
        step(1'b0, 32'd0, 64'd0, 1'b1);
        force_cnt = 1'b0;
        chk_val("t6_wrap", commit_cnt, 64'd0);

        // Random traffic with occasional EBREAK and reset.
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] inst;
            if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 599) == 0) begin
                do_reset();
            end
            inst = ($urandom_range(0, 149) == 0) ? EBRK : rnd_inst();
            step($urandom_range(0, 9) < 7, inst, {$urandom, $urandom},
                 $urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 6 : 9));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
